display_scan_ctrl: RTL

DISPLAY_SCAN_CTRL -- requirements
Module: display_scan_ctrl

---
 rtl/display_scan_ctrl.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/display_scan_ctrl.sv
// Eight-digit multiplexed seven-segment scanner with a one-deep write buffer.
// New display contents are only swapped in while idle or on a frame boundary.
module display_scan_ctrl #(
  parameter int DIV   = 100000,
  parameter int BLANK = 50
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [31:0] wr_data,
  input  logic [7:0]  wr_dp,
  input  logic [7:0]  wr_mask,
  input  logic        wr_valid,
  output logic        wr_ready,
  output logic [7:0]  anode,
  output logic [6:0]  seg,
  output logic        dp_n,
  output logic [2:0]  digit_idx,
  output logic        frame_done
);

  localparam int MAXC = (DIV > BLANK) ? DIV : BLANK;
  localparam int CW   = $clog2(MAXC + 1);

  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK - 1);
  localparam logic [CW-1:0] DIV_LAST   = CW'(DIV - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BLANK = 2'd1;
  localparam logic [1:0] S_DRIVE = 2'd2;

  typedef struct packed {
    logic [31:0] data;
    logic [7:0]  dp;
    logic [7:0]  mask;
  } disp_set_t;

  logic [1:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_idx;
  disp_set_t     r_act;
  disp_set_t     r_pend;
  logic          r_wr_ready;
  logic [7:0]    r_anode;
  logic [6:0]    r_seg;
  logic          r_dp_n;
  logic          r_frame_done;

  logic [1:0]    w_nstate;
  logic [2:0]    w_nidx;
  logic          w_pend_full;
  logic          w_accept;
  logic          w_blank_done;
  logic          w_drive_done;
  logic          w_boundary;
  logic          w_swap;
  logic [3:0]    w_nib;
  logic [7:0]    w_drive_anode;

  function automatic logic [6:0] hexfont(input logic [3:0] h);
    case (h)
      4'h0: hexfont = 7'h40;
      4'h1: hexfont = 7'h79;
      4'h2: hexfont = 7'h24;
      4'h3: hexfont = 7'h30;
      4'h4: hexfont = 7'h19;
      4'h5: hexfont = 7'h12;
      4'h6: hexfont = 7'h02;
      4'h7: hexfont = 7'h78;
      4'h8: hexfont = 7'h00;
      4'h9: hexfont = 7'h10;
      4'hA: hexfont = 7'h08;
      4'hB: hexfont = 7'h03;
      4'hC: hexfont = 7'h46;
      4'hD: hexfont = 7'h21;
      4'hE: hexfont = 7'h06;
      4'hF: hexfont = 7'h0E;
    endcase
  endfunction

  assign w_pend_full  = ~r_wr_ready;
  assign w_accept     = wr_valid & r_wr_ready;
  assign w_blank_done = (r_state == S_BLANK) && (r_cnt == BLANK_LAST);
  assign w_drive_done = (r_state == S_DRIVE) && (r_cnt == DIV_LAST);
  assign w_boundary   = en && w_drive_done && (r_idx == 3'd7);
  // Accept and swap are mutually exclusive: accept needs an empty buffer, swap a full one.
  assign w_swap       = w_pend_full && ((r_state == S_IDLE) || w_boundary);

  always_comb begin
    w_nstate = r_state;
    w_nidx   = r_idx;
    if (!en) begin
      w_nstate = S_IDLE;
      w_nidx   = 3'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_nstate = S_BLANK;
          w_nidx   = 3'd0;
        end
        S_BLANK: if (w_blank_done) w_nstate = S_DRIVE;
        S_DRIVE: if (w_drive_done) begin
          w_nstate = S_BLANK;
          w_nidx   = r_idx + 3'd1;
        end
        default: begin
          w_nstate = S_IDLE;
          w_nidx   = 3'd0;
        end
      endcase
    end
  end

  // Active set never changes on the edge entering DRIVE, so r_act is safe to decode here.
  assign w_nib         = r_act.data[{w_nidx, 2'b00} +: 4];
  assign w_drive_anode = r_act.mask[w_nidx] ? ~(8'b1 << w_nidx) : 8'hFF;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= 3'd0;
    end else begin
      r_state <= w_nstate;
      r_idx   <= w_nidx;
      if ((w_nstate != r_state) || (r_state == S_IDLE)) r_cnt <= '0;
      else                                              r_cnt <= r_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_act      <= '0;
      r_pend     <= '0;
      r_wr_ready <= 1'b1;
    end else begin
      if (w_swap) begin
        r_act      <= r_pend;
        r_wr_ready <= 1'b1;
      end else if (w_accept) begin
        r_pend     <= '{data: wr_data, dp: wr_dp, mask: wr_mask};
        r_wr_ready <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_anode      <= 8'hFF;
      r_seg        <= 7'h7F;
      r_dp_n       <= 1'b1;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_boundary;
      if (w_nstate == S_DRIVE) begin
        r_anode <= w_drive_anode;
        r_seg   <= hexfont(w_nib);
        r_dp_n  <= ~r_act.dp[w_nidx];
      end else begin
        r_anode <= 8'hFF;
        r_seg   <= 7'h7F;
        r_dp_n  <= 1'b1;
      end
    end
  end

  assign wr_ready   = r_wr_ready;
  assign anode      = r_anode;
  assign seg        = r_seg;
  assign dp_n       = r_dp_n;
  assign digit_idx  = r_idx;
  assign frame_done = r_frame_done;

endmodule
